// File: rtl/voice_lut_arbiter.sv
// Purpose: round-robin arbiter sharing one combinational note->divider lookup among NUM_VOICES voices.
// Latency: accept at cycle t -> lut_note/lut_octave at t+2, div_out/div_update at t+4; one lookup per 3 cycles.
// Backpressure: each voice has a single-entry slot; req_ready[v] is low while that slot is pending.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   req_note/req_octave      per-voice note (4b) / octave (3b), packed voice-major
//   req_valid/req_ready      per-voice request handshake
//   lut_note/lut_octave      registered inputs to the shared lookup
//   lut_divider              combinational divider returned by the lookup
//   div_out/div_update       per-voice 19-bit divider and one-cycle update pulse
//   tone_out                 per-voice square wave (only with VOICE_TONE_GEN_EN defined)
// Optional feature macro: VOICE_TONE_GEN_EN adds one divider counter and tone output per voice.
module voice_lut_arbiter #(
    parameter int          NUM_VOICES = 4,
    parameter logic [18:0] OFF_DIV    = 19'd370000
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [4*NUM_VOICES-1:0]  req_note,
    input  logic [3*NUM_VOICES-1:0]  req_octave,
    input  logic [NUM_VOICES-1:0]    req_valid,
    output logic [NUM_VOICES-1:0]    req_ready,
    output logic [3:0]               lut_note,
    output logic [2:0]               lut_octave,
    input  logic [18:0]              lut_divider,
    output logic [19*NUM_VOICES-1:0] div_out,
`ifdef VOICE_TONE_GEN_EN
    output logic [NUM_VOICES-1:0]    tone_out,
`endif
    output logic [NUM_VOICES-1:0]    div_update
);

    localparam int PW = $clog2(NUM_VOICES);

    typedef enum logic [1:0] {IDLE, LOOKUP, CAPTURE} state_t;

    state_t                  state, state_nxt;
    logic [NUM_VOICES-1:0]   pending;
    logic [3:0]              slot_note [NUM_VOICES];
    logic [2:0]              slot_oct  [NUM_VOICES];
    logic [18:0]             div_r     [NUM_VOICES];
    logic [NUM_VOICES-1:0]   upd;
    logic [PW-1:0]           ptr;
    logic [PW-1:0]           grant;
    logic [PW-1:0]           pick;
    logic                    pick_vld;

    // The ready flag is the inverted pending flop, so a voice can never be
    // accepted twice before its lookup has been captured.
    assign req_ready  = ~pending;
    assign div_update = upd;

    always_comb begin
        div_out = '0;
        for (int v = 0; v < NUM_VOICES; v++) begin
            div_out[19*v +: 19] = div_r[v];
        end
    end

    // First pending voice at or after the pointer. Scanning offsets from the
    // far end downwards lets the smallest offset overwrite the others.
    always_comb begin
        int idx;
        idx      = 0;
        pick     = '0;
        pick_vld = 1'b0;
        for (int i = NUM_VOICES - 1; i >= 0; i--) begin
            idx = (int'(ptr) + i) % NUM_VOICES;
            if (pending[idx]) begin
                pick     = PW'(idx);
                pick_vld = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (pick_vld) state_nxt = LOOKUP;
            LOOKUP:  state_nxt = CAPTURE;
            CAPTURE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pending    <= '0;
            upd        <= '0;
            ptr        <= '0;
            grant      <= '0;
            lut_note   <= '0;
            lut_octave <= '0;
            for (int v = 0; v < NUM_VOICES; v++) begin
                slot_note[v] <= '0;
                slot_oct[v]  <= '0;
                div_r[v]     <= OFF_DIV;
            end
        end else begin
            upd <= '0;
            for (int v = 0; v < NUM_VOICES; v++) begin
                if (req_valid[v] && !pending[v]) begin
                    pending[v]   <= 1'b1;
                    slot_note[v] <= req_note[4*v +: 4];
                    slot_oct[v]  <= req_octave[3*v +: 3];
                end
            end
            if (state == IDLE && pick_vld) begin
                grant      <= pick;
                lut_note   <= slot_note[pick];
                lut_octave <= slot_oct[pick];
            end
            // The granted voice is pending, so it cannot be accepted in this
            // same cycle; clearing its flag here never races with an accept.
            if (state == CAPTURE) begin
                div_r[grant]   <= lut_divider;
                upd[grant]     <= 1'b1;
                pending[grant] <= 1'b0;
                ptr            <= (int'(grant) == NUM_VOICES - 1) ? '0 : grant + 1'b1;
            end
        end
    end

`ifdef VOICE_TONE_GEN_EN
    logic [18:0] tcnt [NUM_VOICES];

    // Counter runs 0..div-1; the wrap toggles the tone. A silent divider parks
    // the counter and forces the tone low; a new divider restarts the count
    // without disturbing the current tone level.
    always_ff @(posedge clk) begin
        if (rst) begin
            tone_out <= '0;
            for (int v = 0; v < NUM_VOICES; v++) begin
                tcnt[v] <= '0;
            end
        end else begin
            for (int v = 0; v < NUM_VOICES; v++) begin
                if (div_r[v] == OFF_DIV) begin
                    tcnt[v]     <= '0;
                    tone_out[v] <= 1'b0;
                end else if (upd[v]) begin
                    tcnt[v] <= '0;
                end else if (tcnt[v] == div_r[v] - 19'd1) begin
                    tcnt[v]     <= '0;
                    tone_out[v] <= ~tone_out[v];
                end else begin
                    tcnt[v] <= tcnt[v] + 19'd1;
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_voice_lut_arbiter.sv
// Purpose: randomized + directed bench for voice_lut_arbiter with a queue scoreboard.
// Latency: n/a (testbench).
// Backpressure: requests are held on req_valid until the DUT accepts them.
module tb_voice_lut_arbiter;

    localparam int          NV  = 4;
    localparam logic [18:0] OFF = 19'd370000;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [4*NV-1:0]   req_note   = '0;
    logic [3*NV-1:0]   req_octave = '0;
    logic [NV-1:0]     req_valid  = '0;
    logic [NV-1:0]     req_ready;
    logic [3:0]        lut_note;
    logic [2:0]        lut_octave;
    logic [18:0]       lut_divider;
    logic [19*NV-1:0]  div_out;
    logic [NV-1:0]     div_update;
`ifdef VOICE_TONE_GEN_EN
    logic [NV-1:0]     tone_out;
`endif

    voice_lut_arbiter #(.NUM_VOICES(NV), .OFF_DIV(OFF)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_note   (req_note),
        .req_octave (req_octave),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .lut_note   (lut_note),
        .lut_octave (lut_octave),
        .lut_divider(lut_divider),
        .div_out    (div_out),
`ifdef VOICE_TONE_GEN_EN
        .tone_out   (tone_out),
`endif
        .div_update (div_update)
    );

    always #5 clk = ~clk;

    // Model of the external note->divider table.
    function automatic logic [18:0] lut_fn(input logic [3:0] n, input logic [2:0] o);
        if (n == 4'd0 || n > 4'd13) return OFF;
        if (n == 4'd10 && o == 3'd1) return 19'd109091;
        if (n == 4'd13 && o == 3'd7) return 19'd4;
        return 19'(20000 + int'(n) * 7919 + int'(o) * 1013);
    endfunction

    assign lut_divider = lut_fn(lut_note, lut_octave);

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    logic [18:0] exp_q [NV][$];
    logic [18:0] model_div [NV];
    int          acc_cyc [NV];
    bit          acc_flag [NV];
    int          cap_v[$];
    int          cap_cyc[$];

    task automatic chk(input bit ok, input string name, input longint act, input longint req);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    initial begin
        for (int v = 0; v < NV; v++) model_div[v] = OFF;
    end

    // Monitor: compares every update against the scoreboard and the held values.
    always begin
        @(negedge clk);
        #1;
        cyc++;
        if (div_update != '0) begin
            chk($onehot(div_update), "update_onehot", longint'(div_update), 0);
            for (int v = 0; v < NV; v++) begin
                if (div_update[v]) begin
                    if (exp_q[v].size() == 0) begin
                        chk(1'b0, "unexpected_update", v, -1);
                    end else begin
                        logic [18:0] e;
                        e = exp_q[v].pop_front();
                        chk(div_out[19*v +: 19] == e, "capture_value", longint'(div_out[19*v +: 19]), longint'(e));
                        chk(cyc - acc_cyc[v] <= 4 + 3 * NV, "fair_latency", cyc - acc_cyc[v], 4 + 3 * NV);
                        model_div[v] = e;
                        cap_v.push_back(v);
                        cap_cyc.push_back(cyc);
                    end
                end
            end
        end
        for (int v = 0; v < NV; v++) begin
            chk(div_out[19*v +: 19] == model_div[v], "div_hold", longint'(div_out[19*v +: 19]), longint'(model_div[v]));
        end
    end

    // Registers the accept (or reset) that the next rising edge will perform, then advances.
    task automatic log_and_tick();
        for (int v = 0; v < NV; v++) acc_flag[v] = 1'b0;
        if (rst) begin
            for (int v = 0; v < NV; v++) begin
                exp_q[v].delete();
                model_div[v] = OFF;
            end
        end else begin
            for (int v = 0; v < NV; v++) begin
                if (req_valid[v] && req_ready[v]) begin
                    exp_q[v].push_back(lut_fn(req_note[4*v +: 4], req_octave[3*v +: 3]));
                    acc_cyc[v]  = cyc;
                    acc_flag[v] = 1'b1;
                end
            end
        end
        @(negedge clk);
        #2;
    endtask

    task automatic set_req(input int v, input int n, input int o, input bit vld);
        req_note[4*v +: 4]   = 4'(n);
        req_octave[3*v +: 3] = 3'(o);
        req_valid[v]         = vld;
    endtask

    function automatic bit queues_empty();
        for (int v = 0; v < NV; v++) if (exp_q[v].size() != 0) return 1'b0;
        return 1'b1;
    endfunction

    task automatic wait_idle();
        bit ok;
        ok = 1'b0;
        for (int k = 0; k < 200; k++) begin
            if (req_ready == '1 && queues_empty() && div_update == '0) begin
                ok = 1'b1;
                break;
            end
            log_and_tick();
        end
        chk(ok, "drain_timeout", ok, 1);
    endtask

`ifdef VOICE_TONE_GEN_EN
    task automatic wait_pulse(input int v);
        bit ok;
        ok = 1'b0;
        for (int k = 0; k < 40; k++) begin
            log_and_tick();
            if (div_update[v]) begin
                ok = 1'b1;
                break;
            end
        end
        chk(ok, "pulse_timeout", ok, 1);
    endtask
`endif

    initial begin
        int t0;
        int a0;
        int n_acc;
        // ---------------- reset ----------------
        rst = 1'b1;
        repeat (3) log_and_tick();
        rst = 1'b0;
        chk(req_ready == 4'b1111, "reset_ready", req_ready, 15);
        chk(div_update == 4'b0000, "reset_update", div_update, 0);
        chk(lut_note == 4'd0, "reset_lut_note", lut_note, 0);
        chk(lut_octave == 3'd0, "reset_lut_octave", lut_octave, 0);
        for (int v = 0; v < NV; v++)
            chk(div_out[19*v +: 19] == OFF, "reset_div", longint'(div_out[19*v +: 19]), longint'(OFF));

        // ---------------- single request, exact latency ----------------
        log_and_tick();
        set_req(2, 10, 1, 1'b1);
        t0 = cyc;
        log_and_tick();
        set_req(2, 0, 0, 1'b0);
        chk(acc_flag[2], "single_accept", acc_flag[2], 1);
        chk(req_ready[2] == 1'b0, "single_busy", req_ready[2], 0);
        log_and_tick();
        chk(cyc == t0 + 2, "single_cycle", cyc, t0 + 2);
        chk(lut_note == 4'd10, "lut_note_t2", lut_note, 10);
        chk(lut_octave == 3'd1, "lut_octave_t2", lut_octave, 1);
        log_and_tick();
        chk(div_update == 4'b0000, "no_pulse_t3", div_update, 0);
        log_and_tick();
        chk(div_update == 4'b0100, "pulse_t4", div_update, 4);
        chk(div_out[38 +: 19] == 19'd109091, "div2_t4", longint'(div_out[38 +: 19]), 109091);
        chk(req_ready[2] == 1'b1, "ready_t4", req_ready[2], 1);
        log_and_tick();
        chk(div_update == 4'b0000, "pulse_gone_t5", div_update, 0);

        // ---------------- contention with pointer at 1 ----------------
        wait_idle();
        set_req(0, 3, 2, 1'b1);
        log_and_tick();
        set_req(0, 0, 0, 1'b0);
        wait_idle();
        cap_v.delete();
        cap_cyc.delete();
        set_req(0, 5, 0, 1'b1);
        set_req(1, 6, 3, 1'b1);
        set_req(3, 12, 5, 1'b1);
        log_and_tick();
        req_valid = '0;
        wait_idle();
        chk(cap_v.size() == 3, "rr_count", cap_v.size(), 3);
        if (cap_v.size() == 3) begin
            chk(cap_v[0] == 1, "rr_first", cap_v[0], 1);
            chk(cap_v[1] == 3, "rr_second", cap_v[1], 3);
            chk(cap_v[2] == 0, "rr_third", cap_v[2], 0);
            chk(cap_cyc[1] - cap_cyc[0] == 3, "rr_spacing_a", cap_cyc[1] - cap_cyc[0], 3);
            chk(cap_cyc[2] - cap_cyc[1] == 3, "rr_spacing_b", cap_cyc[2] - cap_cyc[1], 3);
        end
        // Pointer must now be 1: voices 0 and 2 together give 2 first.
        cap_v.delete();
        cap_cyc.delete();
        set_req(0, 1, 1, 1'b1);
        set_req(2, 2, 2, 1'b1);
        log_and_tick();
        req_valid = '0;
        wait_idle();
        chk(cap_v.size() == 2, "ptr_count", cap_v.size(), 2);
        if (cap_v.size() == 2) begin
            chk(cap_v[0] == 2, "ptr_first", cap_v[0], 2);
            chk(cap_v[1] == 0, "ptr_second", cap_v[1], 0);
        end

        // ---------------- busy re-request ----------------
        n_acc = 0;
        a0    = 0;
        set_req(0, 5, 3, 1'b1);
        for (int k = 0; k < 20 && n_acc < 2; k++) begin
            log_and_tick();
            if (acc_flag[0]) begin
                if (n_acc == 0) begin
                    a0 = acc_cyc[0];
                    set_req(0, 7, 4, 1'b1);
                end else begin
                    chk(acc_cyc[0] - a0 == 4, "rereq_gap", acc_cyc[0] - a0, 4);
                    set_req(0, 0, 0, 1'b0);
                end
                n_acc++;
            end
        end
        chk(n_acc == 2, "rereq_accepts", n_acc, 2);
        wait_idle();

        // ---------------- randomized traffic ----------------
        for (int c = 0; c < 400; c++) begin
            for (int v = 0; v < NV; v++) begin
                if (!req_valid[v] || acc_flag[v]) begin
                    if ($urandom_range(0, 2) == 0)
                        set_req(v, int'($urandom_range(0, 15)), int'($urandom_range(0, 7)), 1'b1);
                    else
                        set_req(v, 0, 0, 1'b0);
                end
            end
            log_and_tick();
        end
        req_valid = '0;
        wait_idle();

        // ---------------- reset during LOOKUP ----------------
        set_req(3, 4, 2, 1'b1);
        log_and_tick();
        set_req(3, 0, 0, 1'b0);
        log_and_tick();
        chk(lut_note == 4'd4, "lookup_started", lut_note, 4);
        rst = 1'b1;
        log_and_tick();
        rst = 1'b0;
        chk(req_ready == 4'b1111, "rst_mid_ready", req_ready, 15);
        chk(div_out[57 +: 19] == OFF, "rst_mid_div3", longint'(div_out[57 +: 19]), longint'(OFF));
        for (int k = 0; k < 4; k++) begin
            chk(div_update == 4'b0000, "rst_mid_no_pulse", div_update, 0);
            log_and_tick();
        end

`ifdef VOICE_TONE_GEN_EN
        // ---------------- tone generator ----------------
        begin
            int tog[$];
            logic prev;
            wait_idle();
            set_req(1, 13, 7, 1'b1);
            log_and_tick();
            set_req(1, 0, 0, 1'b0);
            wait_pulse(1);
            prev = tone_out[1];
            for (int k = 0; k < 30; k++) begin
                log_and_tick();
                if (tone_out[1] != prev) tog.push_back(cyc);
                prev = tone_out[1];
            end
            chk(tog.size() >= 5, "tone_toggles", tog.size(), 5);
            for (int i = 1; i < tog.size(); i++)
                chk(tog[i] - tog[i-1] == 4, "tone_half_period", tog[i] - tog[i-1], 4);
            set_req(1, 0, 0, 1'b1);
            log_and_tick();
            set_req(1, 0, 0, 1'b0);
            wait_pulse(1);
            log_and_tick();
            for (int k = 0; k < 6; k++) begin
                chk(tone_out[1] == 1'b0, "tone_off", tone_out[1], 0);
                log_and_tick();
            end
        end
`endif

        chk(queues_empty(), "scoreboard_empty", queues_empty(), 1);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog timeout actual=running required=finished");
        $fatal(1, "watchdog");
    end

endmodule
